// File: rtl/axim_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axim_rd_arbiter
//
// Shares one AXI master read port between C_REQ_NUM loader slots
// (slot 0 = bias, 1 = weight, 2 = ifm). One AR request is granted at a time;
// its burst goes out on the master AR channel, and its R beats are steered
// back to the owning slot until the last beat. Only one burst is ever
// outstanding.
//
// Build option:
//   CNNA_RDARB_FIXPRI_EN  defined   -> fixed priority, lowest slot index wins
//                         undefined -> round-robin starting at rr_ptr (default)
//
// Ports:
//   I_clk, I_rst        clock, synchronous active-high reset
//   I_req_arvalid/araddr/arlen, O_req_arready   per-slot AR channel
//   I_req_rready, O_req_rvalid, O_req_rdata     per-slot R channel (rdata shared)
//   O_maxi_ar*, I_maxi_arready                  master AR channel
//   O_maxi_rready, I_maxi_rvalid, I_maxi_rdata  master R channel
//   O_grant             one-hot owner, 0 when idle
//   O_busy              high while a burst is in address or data phase
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. O_maxi_arvalid, once raised, stays high with stable
// address/length until I_maxi_arready. Per-slot ready/valid outputs are
// combinational and only ever non-zero for the current owner.
// ---------------------------------------------------------------------------
module axim_rd_arbiter #(
  parameter int C_REQ_NUM          = 3,
  parameter int C_M_AXI_LEN_WIDTH  = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128
) (
  input  logic                                      I_clk,
  input  logic                                      I_rst,
  input  logic [C_REQ_NUM-1:0]                      I_req_arvalid,
  input  logic [C_REQ_NUM*C_M_AXI_ADDR_WIDTH-1:0]   I_req_araddr,
  input  logic [C_REQ_NUM*C_M_AXI_LEN_WIDTH-1:0]    I_req_arlen,
  output logic [C_REQ_NUM-1:0]                      O_req_arready,
  input  logic [C_REQ_NUM-1:0]                      I_req_rready,
  output logic [C_REQ_NUM-1:0]                      O_req_rvalid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]             O_req_rdata,
  output logic                                      O_maxi_arvalid,
  input  logic                                      I_maxi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]             O_maxi_araddr,
  output logic [C_M_AXI_LEN_WIDTH-1:0]              O_maxi_arlen,
  output logic                                      O_maxi_rready,
  input  logic                                      I_maxi_rvalid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]             I_maxi_rdata,
  output logic [C_REQ_NUM-1:0]                      O_grant,
  output logic                                      O_busy
);

  localparam int AW    = C_M_AXI_ADDR_WIDTH;
  localparam int LW    = C_M_AXI_LEN_WIDTH;
  localparam int IDX_W = (C_REQ_NUM > 1) ? $clog2(C_REQ_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] win;
  logic [LW-1:0]    beat_cnt;   // beats remaining after the current one
  logic             any_req;
  logic             r_hs;
  logic             last_beat;

  logic [AW-1:0] req_addr [C_REQ_NUM];
  logic [LW-1:0] req_len  [C_REQ_NUM];

  for (genvar i = 0; i < C_REQ_NUM; i++) begin : g_unpack
    assign req_addr[i] = I_req_araddr[i*AW +: AW];
    assign req_len[i]  = I_req_arlen[i*LW +: LW];
  end

  assign any_req = |I_req_arvalid;

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
`ifdef CNNA_RDARB_FIXPRI_EN
  // Descending scan so the lowest requesting index is the last assignment.
  always_comb begin
    win = '0;
    for (int i = C_REQ_NUM - 1; i >= 0; i--) begin
      if (I_req_arvalid[i]) win = IDX_W'(i);
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W:0]   rr_cand;
  logic             rr_found;

  // Search starts at rr_ptr and wraps; one extra bit holds the sum before
  // the modulo fold so non-power-of-two slot counts wrap correctly.
  always_comb begin
    win      = '0;
    rr_found = 1'b0;
    rr_cand  = '0;
    for (int k = 0; k < C_REQ_NUM; k++) begin
      rr_cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (rr_cand >= (IDX_W+1)'(C_REQ_NUM)) rr_cand = rr_cand - (IDX_W+1)'(C_REQ_NUM);
      if (!rr_found && I_req_arvalid[rr_cand[IDX_W-1:0]]) begin
        win      = rr_cand[IDX_W-1:0];
        rr_found = 1'b1;
      end
    end
  end

  // The slot after the one just served gets first look next time.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rr_ptr <= '0;
    end else if (last_beat) begin
      rr_ptr <= (owner_q == IDX_W'(C_REQ_NUM - 1)) ? '0 : owner_q + IDX_W'(1);
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Combinational handshakes (forced low while reset is asserted)
  // -------------------------------------------------------------------------
  assign O_maxi_rready = ~I_rst & (state_q == S_DATA) & I_req_rready[owner_q];
  assign r_hs          = I_maxi_rvalid & O_maxi_rready;
  assign last_beat     = r_hs & (beat_cnt == '0);

  assign O_req_arready = (~I_rst & O_maxi_arvalid & I_maxi_arready) ? O_grant : '0;
  assign O_req_rvalid  = (~I_rst & (state_q == S_DATA) & I_maxi_rvalid) ? O_grant : '0;
  assign O_req_rdata   = I_maxi_rdata;
  assign O_busy        = (state_q != S_IDLE);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req)        state_d = S_ADDR;
      S_ADDR:  if (I_maxi_arready) state_d = S_DATA;
      S_DATA:  if (last_beat)      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q        <= S_IDLE;
      owner_q        <= '0;
      beat_cnt       <= '0;
      O_grant        <= '0;
      O_maxi_arvalid <= 1'b0;
      O_maxi_araddr  <= '0;
      O_maxi_arlen   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q        <= win;
            O_grant        <= {{(C_REQ_NUM-1){1'b0}}, 1'b1} << win;
            O_maxi_araddr  <= req_addr[win];
            O_maxi_arlen   <= req_len[win];
            O_maxi_arvalid <= 1'b1;
          end
        end
        S_ADDR: begin
          if (I_maxi_arready) begin
            O_maxi_arvalid <= 1'b0;
            beat_cnt       <= O_maxi_arlen;
          end
        end
        S_DATA: begin
          if (r_hs) begin
            // Counter stops at zero; the last beat releases the grant.
            if (beat_cnt == '0) O_grant  <= '0;
            else                beat_cnt <= beat_cnt - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axim_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axim_rd_arbiter
//
// Directed scenarios followed by randomized traffic checked against a
// transaction-level reference model (owner id, remaining-beat count,
// round-robin pointer as plain integers).
// ---------------------------------------------------------------------------
module tb_axim_rd_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LW = 32;
  localparam int DW = 128;

`ifdef CNNA_RDARB_FIXPRI_EN
  localparam bit FIXPRI = 1'b1;
`else
  localparam bit FIXPRI = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_arvalid, req_arready, req_rready, req_rvalid, grant;
  logic [N*AW-1:0] req_araddr;
  logic [N*LW-1:0] req_arlen;
  logic [DW-1:0]   req_rdata, maxi_rdata;
  logic            maxi_arvalid, maxi_arready, maxi_rready, maxi_rvalid, busy;
  logic [AW-1:0]   maxi_araddr;
  logic [LW-1:0]   maxi_arlen;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  axim_rd_arbiter #(
    .C_REQ_NUM(N), .C_M_AXI_LEN_WIDTH(LW),
    .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)
  ) dut (
    .I_clk(clk), .I_rst(rst),
    .I_req_arvalid(req_arvalid), .I_req_araddr(req_araddr), .I_req_arlen(req_arlen),
    .O_req_arready(req_arready), .I_req_rready(req_rready),
    .O_req_rvalid(req_rvalid), .O_req_rdata(req_rdata),
    .O_maxi_arvalid(maxi_arvalid), .I_maxi_arready(maxi_arready),
    .O_maxi_araddr(maxi_araddr), .O_maxi_arlen(maxi_arlen),
    .O_maxi_rready(maxi_rready), .I_maxi_rvalid(maxi_rvalid), .I_maxi_rdata(maxi_rdata),
    .O_grant(grant), .O_busy(busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_arvalid  = '0;
    req_araddr   = '0;
    req_arlen    = '0;
    req_rready   = '0;
    maxi_arready = 1'b0;
    maxi_rvalid  = 1'b0;
    maxi_rdata   = '0;
  endtask

  task automatic set_req(input int s, input logic [AW-1:0] a, input logic [LW-1:0] l);
    req_arvalid[s]         = 1'b1;
    req_araddr[s*AW +: AW] = a;
    req_arlen[s*LW +: LW]  = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference arbitration: first requesting slot scanning from ptr (or from 0).
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int s;
      s = FIXPRI ? k : (ptr + k) % N;
      if (v[s]) return s;
    end
    return -1;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    req_arvalid = '1; req_rready = '1; maxi_arready = 1'b1; maxi_rvalid = 1'b1;
    maxi_rdata = 128'h1234_5678;
    tick(); tick();
    n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant got %b want 000", grant); end
    n_checks++; if (maxi_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %b want 0", maxi_arvalid); end
    n_checks++; if (maxi_araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr got %h want 0", maxi_araddr); end
    n_checks++; if (maxi_arlen !== 32'h0) begin n_fail++; $display("FAIL reset_arlen got %h want 0", maxi_arlen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (maxi_rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got %b want 0", maxi_rready); end
    n_checks++; if (req_arready !== 3'b000) begin n_fail++; $display("FAIL reset_req_arready got %b want 000", req_arready); end
    n_checks++; if (req_rvalid !== 3'b000) begin n_fail++; $display("FAIL reset_req_rvalid got %b want 000", req_rvalid); end
    n_checks++; if (req_rdata !== 128'h1234_5678) begin n_fail++; $display("FAIL reset_rdata_bcast got %h want 12345678", req_rdata); end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_burst();
    int cyc, beats, ar_pulses, ar_cyc, stray;
    logic pulse;
    do_reset();
    set_req(1, 32'h1000, 32'd3);
    #1;
    n_checks++; if (maxi_arvalid !== 1'b0) begin n_fail++; $display("FAIL sb_arvalid_early got %b want 0", maxi_arvalid); end
    tick();
    n_checks++; if (maxi_arvalid !== 1'b1) begin n_fail++; $display("FAIL sb_arvalid_lat1 got %b want 1", maxi_arvalid); end
    n_checks++; if (maxi_araddr !== 32'h1000) begin n_fail++; $display("FAIL sb_araddr got %h want 1000", maxi_araddr); end
    n_checks++; if (maxi_arlen !== 32'd3) begin n_fail++; $display("FAIL sb_arlen got %0d want 3", maxi_arlen); end
    n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL sb_grant got %b want 010", grant); end
    cyc = 0; beats = 0; ar_pulses = 0; ar_cyc = -1; stray = 0;
    req_rready[1] = 1'b1;
    maxi_rvalid   = 1'b1;
    while (busy === 1'b1 && cyc < 40) begin
      maxi_arready = (cyc >= 2);
      maxi_rdata   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      pulse = req_arready[1];
      if (pulse) begin ar_pulses++; ar_cyc = cyc; end
      if ((req_arready & 3'b101) != 0 || (req_rvalid & 3'b101) != 0) stray++;
      if (maxi_arvalid && (maxi_rready || req_rvalid != 0)) stray++;
      if (!maxi_arvalid && req_rvalid[1] !== maxi_rready) stray++;
      if (req_rvalid[1] && req_rready[1]) begin
        beats++;
        if (req_rdata !== maxi_rdata) stray++;
      end
      tick();
      if (pulse) req_arvalid[1] = 1'b0;
      cyc++;
    end
    n_checks++; if (ar_pulses != 1) begin n_fail++; $display("FAIL sb_arready_pulses got %0d want 1", ar_pulses); end
    n_checks++; if (ar_cyc != 2) begin n_fail++; $display("FAIL sb_arready_cycle got %0d want 2", ar_cyc); end
    n_checks++; if (beats != 4) begin n_fail++; $display("FAIL sb_beats got %0d want 4", beats); end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL sb_stray_events got %0d want 0", stray); end
    n_checks++; if (cyc != 7) begin n_fail++; $display("FAIL sb_burst_cycles got %0d want 7", cyc); end
    n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL sb_grant_end got %b want 000", grant); end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[$];
    logic [N-1:0] pend, hit;
    int ptr, cyc, s, bad_addr;
    bit reraised;
    do_reset();
    // Expected order from the pending set alone.
    pend = '1; ptr = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) pend = '1;
      s = pick(pend, ptr);
      exp_order.push_back(s);
      if (!(FIXPRI && s == 0)) pend[s] = 1'b0;
      ptr = (s + 1) % N;
    end
    for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), '0);
    maxi_rvalid = 1'b1; req_rready = '1;
    cyc = 0; reraised = 0; bad_addr = 0;
    while (order.size() < 6 && cyc < 100) begin
      maxi_arready = maxi_arvalid;
      maxi_rdata   = DW'(cyc);
      #1;
      hit = req_arready;
      for (int i = 0; i < N; i++) begin
        if (hit[i]) begin
          order.push_back(i);
          if (maxi_araddr !== 32'h100 * (i + 1)) bad_addr++;
        end
      end
      tick();
      for (int i = 0; i < N; i++) if (hit[i] && !(FIXPRI && i == 0)) req_arvalid[i] = 1'b0;
      if (order.size() >= 3 && !reraised) begin
        for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), '0);
        reraised = 1;
      end
      cyc++;
    end
    n_checks++; if (order.size() != 6) begin n_fail++; $display("FAIL rr_count got %0d want 6", order.size()); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= order.size()) begin
        n_fail++; $display("FAIL rr_order[%0d] got none want %0d", i, exp_order[i]);
      end else if (order[i] != exp_order[i]) begin
        n_fail++; $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
      end
    end
    n_checks++; if (bad_addr != 0) begin n_fail++; $display("FAIL rr_addr_mismatches got %0d want 0", bad_addr); end
    idle_inputs();
  endtask

  task automatic test_rready_toggle();
    int cyc, sent, got, bad;
    logic hs, pulse;
    do_reset();
    set_req(2, 32'h2000, 32'd7);
    maxi_arready = 1'b1; maxi_rvalid = 1'b1;
    req_rready = 3'b011;   // non-owners ready: must be ignored
    cyc = 0; sent = 0; got = 0; bad = 0;
    while (cyc < 60) begin
      if (cyc > 0 && busy === 1'b0) break;
      req_rready[2] = (cyc % 2) == 1;
      maxi_rdata    = 128'hA000 + DW'(sent);
      #1;
      if (busy && !maxi_arvalid && maxi_rready !== req_rready[2]) bad++;
      if ((req_rvalid & 3'b011) != 0) bad++;
      hs    = maxi_rvalid && maxi_rready;
      pulse = req_arready[2];
      if (req_rvalid[2] && req_rready[2]) begin
        if (req_rdata !== 128'hA000 + DW'(got)) bad++;
        got++;
      end
      tick();
      if (hs) sent++;
      if (pulse) req_arvalid[2] = 1'b0;
      cyc++;
    end
    n_checks++; if (sent != 8) begin n_fail++; $display("FAIL tog_master_hs got %0d want 8", sent); end
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL tog_owner_beats got %0d want 8", got); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL tog_follow_errors got %0d want 0", bad); end
    n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL tog_grant_end got %b want 000", grant); end
    idle_inputs();
  endtask

  task automatic test_rvalid_in_addr();
    do_reset();
    set_req(0, 32'h3000, '0);
    tick();
    maxi_rvalid = 1'b1; maxi_rdata = 128'hBEEF; req_rready = '1; maxi_arready = 1'b0;
    #1;
    n_checks++; if (maxi_rready !== 1'b0) begin n_fail++; $display("FAIL addr_rready got %b want 0", maxi_rready); end
    n_checks++; if (req_rvalid !== 3'b000) begin n_fail++; $display("FAIL addr_req_rvalid got %b want 000", req_rvalid); end
    tick();
    req_arvalid[0] = 1'b0;   // owner withdraws during the address phase
    #1;
    n_checks++; if (maxi_arvalid !== 1'b1 || maxi_araddr !== 32'h3000) begin
      n_fail++; $display("FAIL addr_hold got %b/%h want 1/3000", maxi_arvalid, maxi_araddr); end
    n_checks++; if (maxi_rready !== 1'b0 || req_rvalid !== 3'b000) begin
      n_fail++; $display("FAIL addr_r_blocked got %b/%b want 0/000", maxi_rready, req_rvalid); end
    maxi_arready = 1'b1;
    #1;
    n_checks++; if (req_arready !== 3'b001) begin n_fail++; $display("FAIL addr_arready got %b want 001", req_arready); end
    tick();
    maxi_arready = 1'b0;
    #1;
    n_checks++; if (req_rvalid !== 3'b001 || maxi_rready !== 1'b1) begin
      n_fail++; $display("FAIL addr_data_beat got %b/%b want 001/1", req_rvalid, maxi_rready); end
    tick();
    n_checks++; if (grant !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL addr_done got %b/%b want 000/0", grant, busy); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    int beats, cyc;
    do_reset();
    set_req(1, 32'h4000, 32'd5);
    maxi_arready = 1'b1; maxi_rvalid = 1'b1; req_rready = '1; maxi_rdata = 128'h77;
    tick();
    tick();
    req_arvalid[1] = 1'b0;
    tick();
    tick();    // beat 2 now on the bus
    n_checks++; if (busy !== 1'b1 || grant !== 3'b010) begin
      n_fail++; $display("FAIL mid_pre got %b/%b want 1/010", busy, grant); end
    rst = 1'b1;
    #1;
    n_checks++; if (maxi_rready !== 1'b0 || req_rvalid !== 3'b000 || req_arready !== 3'b000) begin
      n_fail++; $display("FAIL mid_comb_gate got %b/%b/%b want 0/000/000", maxi_rready, req_rvalid, req_arready); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (grant !== 3'b000 || busy !== 1'b0 || maxi_arvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_regs got %b/%b/%b want 000/0/0", grant, busy, maxi_arvalid); end
    n_checks++; if (maxi_araddr !== 32'h0 || maxi_arlen !== 32'h0) begin
      n_fail++; $display("FAIL mid_ar_clear got %h/%h want 0/0", maxi_araddr, maxi_arlen); end
    n_checks++; if (maxi_rready !== 1'b0 || req_rvalid !== 3'b000) begin
      n_fail++; $display("FAIL mid_r_idle got %b/%b want 0/000", maxi_rready, req_rvalid); end
    set_req(0, 32'h5000, 32'd1);
    maxi_arready = 1'b0;
    tick();
    n_checks++; if (maxi_arvalid !== 1'b1 || grant !== 3'b001 || maxi_araddr !== 32'h5000 || maxi_arlen !== 32'd1) begin
      n_fail++; $display("FAIL mid_new_req got %b/%b/%h/%0d want 1/001/5000/1", maxi_arvalid, grant, maxi_araddr, maxi_arlen); end
    maxi_arready = 1'b1;
    tick();
    req_arvalid[0] = 1'b0;
    beats = 0; cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      #1;
      if (req_rvalid[0] && req_rready[0]) beats++;
      tick();
      cyc++;
    end
    n_checks++; if (beats != 2) begin n_fail++; $display("FAIL mid_new_beats got %0d want 2", beats); end
    idle_inputs();
  endtask

  task automatic test_long_len();
    do_reset();
    set_req(2, 32'h6000, 32'hFFFF_FFFF);
    tick();
    n_checks++; if (maxi_arlen !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL long_arlen got %h want ffffffff", maxi_arlen); end
    maxi_arready = 1'b1;
    tick();
    req_arvalid[2] = 1'b0; maxi_arready = 1'b0;
    maxi_rvalid = 1'b1; req_rready[2] = 1'b1;
    #1;
    n_checks++; if (dut.beat_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL long_cnt_load got %h want ffffffff", dut.beat_cnt); end
    repeat (16) tick();
    n_checks++; if (dut.beat_cnt !== 32'hFFFF_FFEF) begin n_fail++; $display("FAIL long_cnt_16 got %h want ffffffef", dut.beat_cnt); end
    n_checks++; if (busy !== 1'b1 || grant !== 3'b100) begin
      n_fail++; $display("FAIL long_still_busy got %b/%b want 1/100", busy, grant); end
    do_reset();
  endtask

  task automatic test_random();
    int owner, left, ptr, bursts;
    bit in_addr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    logic [N-1:0] exp_grant, exp_arready, exp_rvalid, drop;
    logic exp_rready;
    do_reset();
    owner = -1; left = 0; ptr = 0; in_addr = 0; bursts = 0;
    m_addr = '0; m_len = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!req_arvalid[s] && $urandom_range(0, 3) == 0) set_req(s, $urandom, LW'($urandom_range(0, 4)));
        else if (req_arvalid[s] && $urandom_range(0, 15) == 0) req_arvalid[s] = 1'b0;
        req_rready[s] = ($urandom_range(0, 3) != 0);
      end
      maxi_arready = $urandom_range(0, 1) == 1;
      maxi_rvalid  = $urandom_range(0, 2) != 0;
      maxi_rdata   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      exp_grant   = (owner >= 0) ? (N'(1) << owner) : '0;
      exp_arready = (owner >= 0 && in_addr && maxi_arready) ? exp_grant : '0;
      exp_rready  = (owner >= 0) && !in_addr && req_rready[owner];
      exp_rvalid  = (owner >= 0 && !in_addr && maxi_rvalid) ? exp_grant : '0;
      n_checks++; if (grant !== exp_grant) begin n_fail++; $display("FAIL rnd_grant c=%0d got %b want %b", c, grant, exp_grant); end
      n_checks++; if (busy !== (owner >= 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, owner >= 0); end
      n_checks++; if (maxi_arvalid !== (owner >= 0 && in_addr)) begin n_fail++; $display("FAIL rnd_arvalid c=%0d got %b", c, maxi_arvalid); end
      if (owner >= 0 && in_addr) begin
        n_checks++; if (maxi_araddr !== m_addr || maxi_arlen !== m_len) begin
          n_fail++; $display("FAIL rnd_ar c=%0d got %h/%0d want %h/%0d", c, maxi_araddr, maxi_arlen, m_addr, m_len); end
      end
      n_checks++; if (req_arready !== exp_arready) begin n_fail++; $display("FAIL rnd_arready c=%0d got %b want %b", c, req_arready, exp_arready); end
      n_checks++; if (maxi_rready !== exp_rready) begin n_fail++; $display("FAIL rnd_rready c=%0d got %b want %b", c, maxi_rready, exp_rready); end
      n_checks++; if (req_rvalid !== exp_rvalid) begin n_fail++; $display("FAIL rnd_rvalid c=%0d got %b want %b", c, req_rvalid, exp_rvalid); end
      if (exp_rvalid != 0 && exp_rready) begin
        exp_q.push_back(maxi_rdata);
        n_checks++; if (req_rdata !== exp_q.pop_front()) begin n_fail++; $display("FAIL rnd_rdata c=%0d got %h", c, req_rdata); end
      end
      drop = req_arready;
      // advance the reference model by one clock
      if (owner < 0) begin
        if (req_arvalid != 0) begin
          owner   = pick(req_arvalid, ptr);
          in_addr = 1;
          m_addr  = req_araddr[owner*AW +: AW];
          m_len   = req_arlen[owner*LW +: LW];
        end
      end else if (in_addr) begin
        if (maxi_arready) begin in_addr = 0; left = int'(m_len) + 1; end
      end else if (maxi_rvalid && req_rready[owner]) begin
        left--;
        if (left == 0) begin ptr = (owner + 1) % N; owner = -1; bursts++; end
      end
      tick();
      for (int s = 0; s < N; s++) if (drop[s]) req_arvalid[s] = 1'b0;
    end
    n_checks++; if (bursts < 20) begin n_fail++; $display("FAIL rnd_bursts got %0d want >=20", bursts); end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_rready_toggle();
    test_rvalid_in_addr();
    test_reset_mid_burst();
    test_long_len();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axim_rd_arbiter.md
Name: axim_rd_arbiter

Overview:
- Shares the single AXI master read port between several loaders (bias, weight, ifm) inside cnna.
- Each loader's AR and R channels connect to one requester slot.
- The block arbitrates AR requests, forwards the winning burst to the master port, and steers R beats back to the owner until the burst completes.
- Only one burst is outstanding at a time.

Parameters:
- C_REQ_NUM, 3, number of requester slots (2..8); slot 0=bias, 1=weight, 2=ifm.
- C_M_AXI_LEN_WIDTH, 32, arlen width.
- C_M_AXI_ADDR_WIDTH, 32, araddr width.
- C_M_AXI_DATA_WIDTH, 128, rdata width.

Ports:
- I_clk  in  1  clock; all logic on the rising edge.
- I_rst  in  1  synchronous reset, active-high.
- I_req_arvalid  in  C_REQ_NUM  per-slot read request.
- I_req_araddr  in  C_REQ_NUM*C_M_AXI_ADDR_WIDTH  per-slot address; slot i in bits [i*AW +: AW].
- I_req_arlen  in  C_REQ_NUM*C_M_AXI_LEN_WIDTH  per-slot length; beats = arlen+1.
- O_req_arready  out  C_REQ_NUM  per-slot address accept.
- I_req_rready  in  C_REQ_NUM  per-slot data ready.
- O_req_rvalid  out  C_REQ_NUM  per-slot data valid.
- O_req_rdata  out  C_M_AXI_DATA_WIDTH  rdata, broadcast to all slots.
- O_maxi_arvalid  out  1  master AR valid.
- I_maxi_arready  in  1  master AR ready.
- O_maxi_araddr  out  C_M_AXI_ADDR_WIDTH  master address.
- O_maxi_arlen  out  C_M_AXI_LEN_WIDTH  master length.
- O_maxi_rready  out  1  master R ready.
- I_maxi_rvalid  in  1  master R valid.
- I_maxi_rdata  in  C_M_AXI_DATA_WIDTH  master R data.
- O_grant  out  C_REQ_NUM  one-hot current owner; 0 when idle.
- O_busy  out  1  high in ADDR or DATA.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, beat_cnt=0. O_grant, O_maxi_arvalid, O_maxi_araddr, O_maxi_arlen and O_busy are 0. O_maxi_rready, O_req_arready and O_req_rvalid are 0 combinationally.
- Reset wins over every other event, including mid-burst. Beats still pending at the slave are not drained; the system resets the slave side together with this block.
- States:
  - IDLE: if any I_req_arvalid bit is set, select a winner round-robin, starting the search at slot rr_ptr and wrapping modulo C_REQ_NUM. Register O_grant=onehot(winner). Latch the winner's araddr/arlen into O_maxi_araddr/O_maxi_arlen. Set O_maxi_arvalid=1. Go to ADDR. Latency from requester arvalid to O_maxi_arvalid is 1 cycle.
  - ADDR: hold O_maxi_arvalid and the address/length stable until I_maxi_arready. O_req_arready[g] = O_maxi_arvalid & I_maxi_arready (combinational, one cycle). On the handshake: O_maxi_arvalid<=0, beat_cnt<=arlen, go to DATA. I_maxi_rvalid arriving in ADDR is not accepted (rready=0).
  - DATA: O_maxi_rready = I_req_rready[g]. O_req_rvalid[g] = I_maxi_rvalid; all other slots see 0. O_req_rdata = I_maxi_rdata at all times.
    - On each beat handshake (rvalid & rready): beat_cnt decrements.
    - On the handshake with beat_cnt==0: go to IDLE, O_grant<=0, rr_ptr<=(g+1) mod C_REQ_NUM.
- Next arbitration happens in the IDLE cycle after the last beat, so back-to-back bursts have a 1-cycle bubble.
- Requests arriving while busy are held off: their arready stays 0 and they are served later in round-robin order.
- If the owner drops arvalid during ADDR, the master request still completes; no abort.
- arlen=0 is a single-beat burst. arlen is used at full C_M_AXI_LEN_WIDTH with no truncation.
- Non-owner I_req_rready is ignored.

Optional Feature:
- Macro CNNA_RDARB_FIXPRI_EN.
- Defined: fixed priority, lowest slot index wins; rr_ptr is not implemented.
- Undefined (default): round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Reset, then slot1 requests addr 0x1000, arlen 3; slave arready after 2 cycles, then 4 beats with rvalid continuous → O_maxi_arvalid 1 cycle after request; O_req_arready[1] pulses once; O_req_rvalid[1] for exactly 4 beats; O_grant returns to 0.
- Slots 0,1,2 request simultaneously, arlen 0 each, after reset → serve order 0,1,2; then all re-request → order 0,1,2 again. With CNNA_RDARB_FIXPRI_EN and slot0 always re-requesting → slot0 starves the others.
- Owner slot2 toggles I_req_rready 1/0 during an arlen 7 burst → O_maxi_rready follows it; exactly 8 handshakes; no beat lost or duplicated.
- I_maxi_rvalid asserted during ADDR before arready → O_maxi_rready=0 and no O_req_rvalid.
- I_rst asserted on beat 2 of an arlen 5 burst → next cycle all outputs 0 and state IDLE; a new slot0 request then proceeds normally.
- arlen=0xFFFF_FFFF latched → O_maxi_arlen carries the full 32-bit value; beat_cnt loads it with no overflow (check via a forced early-terminate assertion on the counter value).
